md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width.
REQ-002 SHALL have parameter MULT_LAT, default 5, busy cycles for multiply-class ops (>=1).
REQ-003 SHALL have parameter DIV_LAT, default 10, busy cycles for divide ops (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  issue strobe, one cycle per op.
REQ-007 SHALL have port op  input  3  operation code (md_pkg).
REQ-008 SHALL have port is_signed  input  1  1 = signed MULT/DIV/MADD/MSUB.
REQ-009 SHALL have port src_a  input  WIDTH  rs operand.
REQ-010 SHALL have port src_b  input  WIDTH  rt operand.
REQ-011 SHALL have port cancel  input  1  exception flush of in-flight op.
REQ-012 SHALL have port busy  output  1  computation in progress.
REQ-013 SHALL have port hi  output  WIDTH  architectural HI.
REQ-014 SHALL have port lo  output  WIDTH  architectural LO.

Function
REQ-015 SHALL decode op: 000 NONE, 001 MULT, 010 DIV, 011 MTHI, 100 MTLO, 101 MADD, 110 MSUB, 111 reserved (treated as NONE).
REQ-016 SHALL implement two-state FSM IDLE/RUN; counter loaded with MULT_LAT (MULT/MADD/MSUB) or DIV_LAT (DIV) on accepted start.
REQ-017 SHALL accept start only in IDLE with cancel low; start in RUN or with cancel high is ignored, no state change.
REQ-018 SHALL assert busy from the cycle after acceptance for exactly the loaded latency cycles; busy low in start cycle itself.
REQ-019 SHALL compute the result from operands captured at acceptance into a pending {hi,lo} register; later operand changes have no effect.
REQ-020 SHALL commit pending {hi,lo} on the last RUN cycle's edge: hi/lo updated and busy low in the same following cycle; FSM returns to IDLE.
REQ-021 SHALL form MULT as 2*WIDTH product, hi = upper half, lo = lower half; signed/unsigned per is_signed.
REQ-022 SHALL form DIV with lo = quotient, hi = remainder (remainder sign follows dividend when signed).
REQ-023 SHALL on divide by zero commit lo = all ones, hi = src_a.
REQ-024 SHALL on signed DIV of most-negative by -1 commit lo = most-negative, hi = 0.
REQ-025 SHALL form MADD/MSUB as {hi,lo} +/- product, modulo 2^(2*WIDTH), using {hi,lo} at acceptance.
REQ-026 SHALL execute MTHI/MTLO in one cycle: hi (or lo) = src_a at next edge, busy stays low, FSM stays IDLE.
REQ-027 SHALL ignore MTHI/MTLO issued while busy (hazard logic stalls them; no write occurs).
REQ-028 SHALL on cancel in RUN discard pending result, return to IDLE, deassert busy next cycle, hi/lo keep pre-op values.
REQ-029 SHALL give cancel priority over commit when both occur in the last RUN cycle (no write).

Reset
REQ-030 SHALL on reset_n low immediately force IDLE, counter 0, busy 0, hi 0, lo 0, pending 0, including mid-operation.
REQ-031 SHALL resume accepting start on the first edge after reset_n deasserts.

Configuration
REQ-032 SHALL use macro MD_UNIT_MADD_EN: defined -> MADD/MSUB operate per REQ-025; undefined -> MADD/MSUB decode as NONE (ignored, no busy, no hi/lo change) and accumulate logic absent.

Structure
REQ-033 SHALL place op codes, op width, and default latencies in shared package md_pkg, also used by the controller.
REQ-034 SHALL factor the latency down-counter with load/clear/done into sub-module md_lat_counter.

Verification
REQ-035 SHALL test MULT signed 0xFFFFFFFE*0x00000003 -> after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 SHALL test DIV signed 0xFFFFFFF9 / 2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divisor 0 -> lo=0xFFFFFFFF, hi=src_a.
REQ-037 SHALL test start during busy (MULT then DIV on busy cycle 2) -> DIV ignored, MULT result only, busy total 5 cycles.
REQ-038 SHALL test cancel on busy cycle 3 of MULT with hi=0x11, lo=0x22 -> busy low next cycle, hi=0x11, lo=0x22 unchanged.
REQ-039 SHALL test MTHI 0xABCD then MTLO 0x1234 back-to-back -> hi=0xABCD, lo=0x1234 on following cycles, busy never high.
REQ-040 SHALL test MADD unsigned with hi=0, lo=0xFFFFFFFF, 1*1 (macro defined) -> hi=1, lo=0; with macro undefined -> no change.

Source files
------------

// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg -- shared definitions for the multiply/divide unit.
//   * MD_OP_W / md_op_e : operation code width and encoding
//   * md_state_e        : controller states
//   * default multiply / divide latencies
//   * md_cnt_width()    : width needed by the latency down-counter
// No ports (package).
// ---------------------------------------------------------------------------
package md_pkg;

  localparam int MD_OP_W         = 3;
  localparam int MD_DEF_MULT_LAT = 5;
  localparam int MD_DEF_DIV_LAT  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    OP_NONE = 3'b000,
    OP_MULT = 3'b001,
    OP_DIV  = 3'b010,
    OP_MTHI = 3'b011,
    OP_MTLO = 3'b100,
    OP_MADD = 3'b101,
    OP_MSUB = 3'b110,
    OP_RSVD = 3'b111
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Counter must hold the larger of the two latencies.
  function automatic int md_cnt_width(input int mult_lat, input int div_lat);
    int max_lat;
    max_lat = (mult_lat > div_lat) ? mult_lat : div_lat;
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// ---------------------------------------------------------------------------
// md_lat_counter -- latency down-counter for the multiply/divide unit.
// Ports:
//   clk_i       clock, rising edge
//   reset_n_i   asynchronous active-low reset (count -> 0)
//   load_i      load load_val_i into the counter
//   load_val_i  number of busy cycles of the accepted operation
//   clear_i     discard the count (takes priority over load)
//   done_o      high during the last busy cycle (count == 1)
// ---------------------------------------------------------------------------
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             clear_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: clear, load, then free-running decrement down to zero.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign done_o = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- MIPS-style HI/LO multiply/divide unit.
// Results are computed from operands captured at issue, held in a pending
// {hi,lo} register, and committed after MULT_LAT / DIV_LAT busy cycles.
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      issue strobe (one cycle per operation)
//   op         operation code (md_pkg::md_op_e)
//   is_signed  signed MULT/DIV/MADD/MSUB
//   src_a      rs operand
//   src_b      rt operand
//   cancel     flush of the in-flight operation
//   busy       computation in progress (registered)
//   hi, lo     architectural HI / LO (registered)
// Build option: define MD_UNIT_MADD_EN to enable MADD/MSUB; otherwise they
// decode as NONE and the accumulate datapath is not built.
// ---------------------------------------------------------------------------
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = MD_DEF_MULT_LAT,
  parameter int DIV_LAT  = MD_DEF_DIV_LAT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               cancel,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int               CNT_W      = md_cnt_width(MULT_LAT, DIV_LAT);
  localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e            state_q;
  logic                 busy_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [2*WIDTH-1:0]   pending_q;
  logic [2*WIDTH-1:0]   pending_d;

  md_op_e               op_s;
  logic                 accept_s;
  logic                 long_s;
  logic [CNT_W-1:0]     lat_s;
  logic                 load_s;
  logic                 clear_s;
  logic                 cnt_done_s;
  logic [2*WIDTH-1:0]   a_ext_s;
  logic [2*WIDTH-1:0]   b_ext_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  // Decode the raw op into the effective operation for this build.
  always_comb begin
    op_s = OP_NONE;
    case (md_op_e'(op))
      OP_MULT: op_s = OP_MULT;
      OP_DIV:  op_s = OP_DIV;
      OP_MTHI: op_s = OP_MTHI;
      OP_MTLO: op_s = OP_MTLO;
`ifdef MD_UNIT_MADD_EN
      OP_MADD: op_s = OP_MADD;
      OP_MSUB: op_s = OP_MSUB;
`endif
      default: op_s = OP_NONE;
    endcase
  end

  assign accept_s = (state_q == ST_IDLE) && start && !cancel;

  // Multi-cycle classification and the latency to load for it.
  always_comb begin
    long_s = 1'b0;
    lat_s  = MULT_LAT_C;
    case (op_s)
      OP_MULT, OP_MADD, OP_MSUB: begin
        long_s = 1'b1;
        lat_s  = MULT_LAT_C;
      end
      OP_DIV: begin
        long_s = 1'b1;
        lat_s  = DIV_LAT_C;
      end
      default: begin
        long_s = 1'b0;
        lat_s  = MULT_LAT_C;
      end
    endcase
  end

  // Extending both operands to 2*WIDTH makes the truncated product correct
  // for signed and unsigned alike.
  always_comb begin
    if (is_signed) begin
      a_ext_s = {{WIDTH{src_a[WIDTH-1]}}, src_a};
      b_ext_s = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    end else begin
      a_ext_s = {{WIDTH{1'b0}}, src_a};
      b_ext_s = {{WIDTH{1'b0}}, src_b};
    end
  end

  assign prod_s = a_ext_s * b_ext_s;

  // Quotient/remainder with the divide-by-zero and overflow cases pinned.
  always_comb begin
    if (src_b == {WIDTH{1'b0}}) begin
      quo_s = {WIDTH{1'b1}};
      rem_s = src_a;
    end else if (is_signed && (src_a == MOST_NEG) && (src_b == {WIDTH{1'b1}})) begin
      quo_s = MOST_NEG;
      rem_s = {WIDTH{1'b0}};
    end else if (is_signed) begin
      quo_s = $signed(src_a) / $signed(src_b);
      rem_s = $signed(src_a) % $signed(src_b);
    end else begin
      quo_s = src_a / src_b;
      rem_s = src_a % src_b;
    end
  end

  // Result captured into the pending register on acceptance.
  always_comb begin
    pending_d = pending_q;
    case (op_s)
      OP_MULT: pending_d = prod_s;
      OP_DIV:  pending_d = {rem_s, quo_s};
`ifdef MD_UNIT_MADD_EN
      OP_MADD: pending_d = {hi_q, lo_q} + prod_s;
      OP_MSUB: pending_d = {hi_q, lo_q} - prod_s;
`endif
      default: pending_d = pending_q;
    endcase
  end

  assign load_s  = accept_s && long_s;
  assign clear_s = (state_q == ST_RUN) && cancel;

  md_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .load_i     (load_s),
    .load_val_i (lat_s),
    .clear_i    (clear_s),
    .done_o     (cnt_done_s)
  );

  // Controller FSM with registered busy/hi/lo; cancel beats commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      pending_q <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && long_s) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            pending_q <= pending_d;
          end else if (accept_s && (op_s == OP_MTHI)) begin
            hi_q <= src_a;
          end else if (accept_s && (op_s == OP_MTLO)) begin
            lo_q <= src_a;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cancel) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            pending_q <= {(2*WIDTH){1'b0}};
          end else if (cnt_done_s) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            hi_q      <= pending_q[2*WIDTH-1:WIDTH];
            lo_q      <= pending_q[WIDTH-1:0];
            pending_q <= {(2*WIDTH){1'b0}};
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic        is_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int n;

  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .is_signed (is_signed),
    .src_a     (src_a),
    .src_b     (src_b),
    .cancel    (cancel),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, then count busy cycles; optionally inject a DIV start or
  // a cancel on a given busy cycle (1-based, 0 = never).
  task automatic run_op(input logic [2:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input int inj, input int cnl, output int cnt);
    start = 1'b1; op = o; is_signed = s; src_a = a; src_b = b;
    tick();
    start = 1'b0; op = OP_NONE; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0001;
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      cancel = (cnt == cnl);
      if (cnt == inj) begin
        start = 1'b1; op = OP_DIV; is_signed = 1'b0; src_a = 32'd100; src_b = 32'd5;
      end else begin
        start = 1'b0; op = OP_NONE;
      end
      tick();
    end
    start = 1'b0; cancel = 1'b0; op = OP_NONE;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    start = 1'b1; op = o; src_a = v;
    tick();
    start = 1'b0; op = OP_NONE;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = OP_NONE; is_signed = 1'b0;
    src_a = 32'h0; src_b = 32'h0; cancel = 1'b0;
    tick(); tick();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset_n = 1'b1;

    // signed MULT -2 * 3, issued on the first edge after reset release
    run_op(OP_MULT, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0, n);
    check("mul_s_cycles", n, 32'd5);
    check("mul_s_hi", hi, 32'hFFFF_FFFF);
    check("mul_s_lo", lo, 32'hFFFF_FFFA);

    // signed DIV -7 / 2
    run_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, n);
    check("div_s_cycles", n, 32'd10);
    check("div_s_lo", lo, 32'hFFFF_FFFD);
    check("div_s_hi", hi, 32'hFFFF_FFFF);

    // divide by zero
    run_op(OP_DIV, 1'b0, 32'h1234_5678, 32'h0000_0000, 0, 0, n);
    check("div0_cycles", n, 32'd10);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234_5678);

    // signed most-negative / -1
    run_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0000_0000);

    // unsigned DIV 100 / 7
    run_op(OP_DIV, 1'b0, 32'd100, 32'd7, 0, 0, n);
    check("div_u_lo", lo, 32'd14);
    check("div_u_hi", hi, 32'd2);

    // unsigned MULT max*max
    run_op(OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, n);
    check("mul_u_hi", hi, 32'hFFFF_FFFE);
    check("mul_u_lo", lo, 32'h0000_0001);

    // DIV issued on busy cycle 2 of a MULT is ignored
    run_op(OP_MULT, 1'b0, 32'd6, 32'd7, 2, 0, n);
    check("stall_cycles", n, 32'd5);
    check("stall_hi", hi, 32'd0);
    check("stall_lo", lo, 32'd42);
    tick();
    check("stall_idle", {31'h0, busy}, 32'h0);

    // MTHI then MTLO back-to-back
    start = 1'b1; op = OP_MTHI; src_a = 32'h0000_ABCD;
    tick();
    check("mthi_hi", hi, 32'h0000_ABCD);
    check("mthi_busy", {31'h0, busy}, 32'h0);
    op = OP_MTLO; src_a = 32'h0000_1234;
    tick();
    start = 1'b0; op = OP_NONE;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi", hi, 32'h0000_ABCD);
    check("mtlo_busy", {31'h0, busy}, 32'h0);

    // cancel on busy cycle 3
    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    run_op(OP_MULT, 1'b0, 32'd5, 32'd5, 0, 3, n);
    check("cnl_cycles", n, 32'd3);
    check("cnl_hi", hi, 32'h11);
    check("cnl_lo", lo, 32'h22);

    // cancel in the last busy cycle wins over commit
    run_op(OP_MULT, 1'b0, 32'd5, 32'd5, 0, 5, n);
    check("cnl_last_cycles", n, 32'd5);
    check("cnl_last_hi", hi, 32'h11);
    check("cnl_last_lo", lo, 32'h22);

    // start with cancel high in IDLE is ignored
    cancel = 1'b1;
    mt(OP_MTHI, 32'h99);
    cancel = 1'b0;
    check("idle_cnl_hi", hi, 32'h11);

    // reserved op is a no-op
    run_op(3'b111, 1'b0, 32'h5555_5555, 32'd3, 0, 0, n);
    check("rsvd_cycles", n, 32'd0);
    check("rsvd_hi", hi, 32'h11);
    check("rsvd_lo", lo, 32'h22);

    // MADD / MSUB
    mt(OP_MTHI, 32'h0);
    mt(OP_MTLO, 32'hFFFF_FFFF);
    run_op(OP_MADD, 1'b0, 32'd1, 32'd1, 0, 0, n);
`ifdef MD_UNIT_MADD_EN
    check("madd_cycles", n, 32'd5);
    check("madd_hi", hi, 32'h1);
    check("madd_lo", lo, 32'h0);
`else
    check("madd_cycles", n, 32'd0);
    check("madd_hi", hi, 32'h0);
    check("madd_lo", lo, 32'hFFFF_FFFF);
`endif
    run_op(OP_MSUB, 1'b0, 32'd2, 32'd3, 0, 0, n);
`ifdef MD_UNIT_MADD_EN
    check("msub_cycles", n, 32'd5);
    check("msub_hi", hi, 32'h0);
    check("msub_lo", lo, 32'hFFFF_FFFA);
`else
    check("msub_cycles", n, 32'd0);
    check("msub_hi", hi, 32'h0);
    check("msub_lo", lo, 32'hFFFF_FFFF);
`endif

    // asynchronous reset in the middle of a DIV
    mt(OP_MTHI, 32'h0000_00AA);
    start = 1'b1; op = OP_DIV; is_signed = 1'b0; src_a = 32'd9; src_b = 32'd3;
    tick();
    start = 1'b0; op = OP_NONE;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    #1 reset_n = 1'b1;
    mt(OP_MTHI, 32'h77);
    check("postrst_hi", hi, 32'h77);
    check("postrst_busy", {31'h0, busy}, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
